// File: rtl/cordic_pkg.sv
// Shared constants and types for the pipelined CORDIC atan2/magnitude engine.
// Angles are degrees in Q.16; the gain constant is 1/CORDIC-gain in Q.16.
package cordic_pkg;

  localparam int ATAN_Q16 [0:15] = '{
    1740967, 919879, 466945, 234379, 117304, 58666, 29335, 14668,
    7334, 3667, 1833, 917, 458, 229, 115, 57
  };

  localparam int K_Q16         = 39797;
  localparam int ANGLE_45_Q16  = 2949120;
  localparam int ANGLE_135_Q16 = 8847360;

  typedef enum logic [1:0] {
    QUAD_XP_YP = 2'b00,
    QUAD_XP_YN = 2'b01,
    QUAD_XN_YP = 2'b10,
    QUAD_XN_YN = 2'b11
  } quad_e;

endpackage

// File: rtl/cordic_stage.sv
// One registered CORDIC vectoring micro-rotation, shifting by SHIFT and
// steering y toward zero; valid and zero flags travel alongside the data.
module cordic_stage
  import cordic_pkg::*;
#(
  parameter int W     = 21,
  parameter int SHIFT = 1,
  parameter int AW    = 26
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_en,
  input  logic                 i_valid,
  input  logic                 i_zero,
  input  logic signed [W-1:0]  i_x,
  input  logic signed [W-1:0]  i_y,
  input  logic signed [AW-1:0] i_a,
  output logic                 o_valid,
  output logic                 o_zero,
  output logic signed [W-1:0]  o_x,
  output logic signed [W-1:0]  o_y,
  output logic signed [AW-1:0] o_a
);

  localparam logic signed [AW-1:0] STEP = AW'(ATAN_Q16[SHIFT-1]);

  logic signed [W-1:0]  x_d, x_q, y_d, y_q;
  logic signed [AW-1:0] a_d, a_q;
  logic                 valid_d, valid_q, zero_d, zero_q;

  always_comb begin
    valid_d = i_valid;
    zero_d  = i_zero;
    if (i_y[W-1]) begin
      x_d = i_x - (i_y >>> SHIFT);
      y_d = i_y + (i_x >>> SHIFT);
      a_d = i_a - STEP;
    end else begin
      x_d = i_x + (i_y >>> SHIFT);
      y_d = i_y - (i_x >>> SHIFT);
      a_d = i_a + STEP;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      x_q     <= '0;
      y_q     <= '0;
      a_q     <= '0;
      valid_q <= 1'b0;
      zero_q  <= 1'b0;
    end else if (i_en) begin
      x_q     <= x_d;
      y_q     <= y_d;
      a_q     <= a_d;
      valid_q <= valid_d;
      zero_q  <= zero_d;
    end
  end

  assign o_x     = x_q;
  assign o_y     = y_q;
  assign o_a     = a_q;
  assign o_valid = valid_q;
  assign o_zero  = zero_q;

endmodule

// File: rtl/cordic_atan2_pipe.sv
// Fully pipelined CORDIC vectoring: (x,y) -> atan2 angle in degrees plus
// gain-compensated magnitude; latency ITER+2 enabled edges, one sample per edge.
module cordic_atan2_pipe
  import cordic_pkg::*;
#(
  parameter int IN_W    = 10,
  parameter int ITER    = 13,
  parameter int PREC    = 9,
  parameter int ANGLE_W = 18,
  parameter int FRAC_W  = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_en,
  input  logic                      i_valid,
  input  logic signed [IN_W-1:0]    i_xval,
  input  logic signed [IN_W-1:0]    i_yval,
  output logic                      o_valid,
  output logic signed [ANGLE_W-1:0] o_angle,
  output logic signed [8:0]         o_angle_int,
  output logic [IN_W:0]             o_mag,
  output logic                      o_zero
);

  localparam int W  = IN_W + PREC + 2;
  localparam int AW = ANGLE_W - FRAC_W + 16;

  if (ITER < 1 || ITER > 16) begin : g_bad_iter
    $error("cordic_atan2_pipe: ITER must be in 1..16");
  end
  if (ANGLE_W - FRAC_W < 10 || FRAC_W < 1 || FRAC_W > 16) begin : g_bad_angle
    $error("cordic_atan2_pipe: need ANGLE_W-FRAC_W >= 10 and FRAC_W in 1..16");
  end
  if (IN_W < 4 || IN_W > 16) begin : g_bad_in_w
    $error("cordic_atan2_pipe: IN_W must be in 4..16");
  end

  localparam logic signed [AW-1:0]      A45     = AW'(ANGLE_45_Q16);
  localparam logic signed [AW-1:0]      A135    = AW'(ANGLE_135_Q16);
  localparam logic signed [ANGLE_W-1:0] ANG_MAX = ANGLE_W'(180 * (2 ** FRAC_W));
  localparam logic signed [ANGLE_W-1:0] ANG_MIN = ANGLE_W'(1 - 180 * (2 ** FRAC_W));
  localparam logic signed [ANGLE_W:0]   HALF    = (ANGLE_W+1)'(2 ** (FRAC_W - 1));
  localparam logic [W+15:0]             MAG_RND = (W+16)'(1) << (15 + PREC);

  quad_e                quad;
  logic signed [W-1:0]  x_ext, y_ext;
  logic signed [W-1:0]  x0_d, x0_q, y0_d, y0_q;
  logic signed [AW-1:0] a0_d, a0_q;
  logic                 valid0_d, valid0_q, zero0_d, zero0_q;

  // Pre-rotation folds every quadrant into the right half-plane; it doubles
  // as iteration zero, so its sqrt(2) gain is part of K_Q16.
  always_comb begin
    x_ext    = W'(i_xval) <<< PREC;
    y_ext    = W'(i_yval) <<< PREC;
    quad     = quad_e'({i_xval[IN_W-1], i_yval[IN_W-1]});
    valid0_d = i_valid;
    zero0_d  = (i_xval == '0) && (i_yval == '0);
    x0_d     = x_ext + y_ext;
    y0_d     = y_ext - x_ext;
    a0_d     = A45;
    case (quad)
      QUAD_XP_YP: begin x0_d = x_ext + y_ext;  y0_d = y_ext - x_ext;  a0_d = A45;   end
      QUAD_XN_YP: begin x0_d = y_ext - x_ext;  y0_d = -x_ext - y_ext; a0_d = A135;  end
      QUAD_XN_YN: begin x0_d = -x_ext - y_ext; y0_d = x_ext - y_ext;  a0_d = -A135; end
      QUAD_XP_YN: begin x0_d = x_ext - y_ext;  y0_d = x_ext + y_ext;  a0_d = -A45;  end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      x0_q     <= '0;
      y0_q     <= '0;
      a0_q     <= '0;
      valid0_q <= 1'b0;
      zero0_q  <= 1'b0;
    end else if (i_en) begin
      x0_q     <= x0_d;
      y0_q     <= y0_d;
      a0_q     <= a0_d;
      valid0_q <= valid0_d;
      zero0_q  <= zero0_d;
    end
  end

  logic signed [W-1:0]  x_s     [0:ITER];
  logic signed [W-1:0]  y_s     [0:ITER];
  logic signed [AW-1:0] a_s     [0:ITER];
  logic                 valid_s [0:ITER];
  logic                 zero_s  [0:ITER];

  assign x_s[0]     = x0_q;
  assign y_s[0]     = y0_q;
  assign a_s[0]     = a0_q;
  assign valid_s[0] = valid0_q;
  assign zero_s[0]  = zero0_q;

  for (genvar k = 1; k <= ITER; k++) begin : g_stage
    cordic_stage #(.W(W), .SHIFT(k), .AW(AW)) u_stage (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_en    (i_en),
      .i_valid (valid_s[k-1]),
      .i_zero  (zero_s[k-1]),
      .i_x     (x_s[k-1]),
      .i_y     (y_s[k-1]),
      .i_a     (a_s[k-1]),
      .o_valid (valid_s[k]),
      .o_zero  (zero_s[k]),
      .o_x     (x_s[k]),
      .o_y     (y_s[k]),
      .o_a     (a_s[k])
    );
  end

  logic signed [ANGLE_W-1:0] ang_trunc, angle_d, angle_q;
  logic signed [ANGLE_W:0]   ang_rnd;
  logic signed [8:0]         angle_int_d, angle_int_q;
  logic [IN_W:0]             mag_d, mag_q;
  logic                      valid_d, valid_q, zero_d, zero_q;

  // Residual error can push the angle just past +/-180; clamp into (-180,+180].
  always_comb begin
    valid_d   = valid_s[ITER];
    zero_d    = zero_s[ITER];
    ang_trunc = ANGLE_W'(a_s[ITER] >>> (16 - FRAC_W));
    if (ang_trunc > ANG_MAX) begin
      angle_d = ANG_MAX;
    end else if (ang_trunc < ANG_MIN) begin
      angle_d = ANG_MIN;
    end else begin
      angle_d = ang_trunc;
    end
    mag_d = (IN_W+1)'((((W+16)'($unsigned(x_s[ITER])) * (W+16)'(K_Q16)) + MAG_RND)
                      >> (16 + PREC));
    if (zero_s[ITER]) begin
      angle_d = '0;
      mag_d   = '0;
    end
    ang_rnd     = (ANGLE_W+1)'(angle_d) + HALF;
    angle_int_d = 9'(ang_rnd >>> FRAC_W);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      angle_q     <= '0;
      angle_int_q <= '0;
      mag_q       <= '0;
      valid_q     <= 1'b0;
      zero_q      <= 1'b0;
    end else if (i_en) begin
      angle_q     <= angle_d;
      angle_int_q <= angle_int_d;
      mag_q       <= mag_d;
      valid_q     <= valid_d;
      zero_q      <= zero_d;
    end
  end

  assign o_valid     = valid_q;
  assign o_angle     = angle_q;
  assign o_angle_int = angle_int_q;
  assign o_mag       = mag_q;
  assign o_zero      = zero_q;

endmodule

// File: tb/tb_cordic_atan2_pipe.sv
// Self-checking bench for cordic_atan2_pipe: a delay line of enabled edges
// tracks samples, and each result is compared with real-valued atan2/sqrt.
module tb_cordic_atan2_pipe;

  localparam int  IN_W    = 10;
  localparam int  ITER    = 13;
  localparam int  PREC    = 9;
  localparam int  ANGLE_W = 18;
  localparam int  FRAC_W  = 8;
  localparam int  L       = ITER + 2;
  localparam int  ONE_DEG = 2 ** FRAC_W;
  localparam real PI      = 3.14159265358979;

  typedef struct {
    bit v;
    bit strict;
    int x;
    int y;
  } sample_t;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      en;
  logic                      iValid;
  logic signed [IN_W-1:0]    iX;
  logic signed [IN_W-1:0]    iY;
  logic                      oValid;
  logic signed [ANGLE_W-1:0] oAngle;
  logic signed [8:0]         oAngleInt;
  logic [IN_W:0]             oMag;
  logic                      oZero;
  bit                        strictNow;

  sample_t pipeQ[$];
  int      checks = 0;
  int      fails  = 0;

  cordic_atan2_pipe #(
    .IN_W(IN_W), .ITER(ITER), .PREC(PREC), .ANGLE_W(ANGLE_W), .FRAC_W(FRAC_W)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_en        (en),
    .i_valid     (iValid),
    .i_xval      (iX),
    .i_yval      (iY),
    .o_valid     (oValid),
    .o_angle     (oAngle),
    .o_angle_int (oAngleInt),
    .o_mag       (oMag),
    .o_zero      (oZero)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected,
                             input int tol);
    checks++;
    if (observed - expected > tol || expected - observed > tol) begin
      fails++;
      $display("[TB] FAIL %s: observed %0d, expected %0d (tol %0d) at %0t",
               tag, observed, expected, tol, $time);
    end
  endtask

  function automatic int wrapTo(input int observed, input int expected, input int full);
    if (observed - expected > full / 2) return expected + full;
    if (expected - observed > full / 2) return expected - full;
    return expected;
  endfunction

  task automatic checkSample(input sample_t s);
    real ang;
    int  expAng, expInt, expMag, obsAng, obsInt;
    obsAng = int'(oAngle);
    obsInt = int'(oAngleInt);
    if (s.x == 0 && s.y == 0) begin
      checkOutput("zeroFlag", int'(oZero), 1, 0);
      checkOutput("zeroAngle", obsAng, 0, 0);
      checkOutput("zeroAngleInt", obsInt, 0, 0);
      checkOutput("zeroMag", int'(oMag), 0, 0);
    end else begin
      ang    = $atan2(real'(s.y), real'(s.x)) * 180.0 / PI;
      expAng = $rtoi($floor(ang * ONE_DEG + 0.5));
      expInt = $rtoi($floor(ang + 0.5));
      expMag = $rtoi($floor($sqrt(real'(s.x * s.x + s.y * s.y)) + 0.5));
      checkOutput("zeroFlag", int'(oZero), 0, 0);
      checkOutput("angle", obsAng, wrapTo(obsAng, expAng, 360 * ONE_DEG),
                  s.strict ? 13 : ONE_DEG);
      checkOutput("angleInt", obsInt, wrapTo(obsInt, expInt, 360), s.strict ? 0 : 1);
      checkOutput("mag", int'(oMag), expMag, 1);
    end
  endtask

  // Reference delay line: one entry per enabled edge, result due after L entries.
  always @(posedge clk or posedge rst) begin : modelBlk
    sample_t s;
    if (rst) begin
      pipeQ.delete();
    end else if (en) begin
      s.v      = iValid;
      s.strict = strictNow;
      s.x      = int'(iX);
      s.y      = int'(iY);
      pipeQ.push_back(s);
      if (pipeQ.size() > L) void'(pipeQ.pop_front());
    end
  end

  always @(negedge clk) begin : monitorBlk
    bit expV;
    expV = (pipeQ.size() == L) && pipeQ[0].v;
    checkOutput("valid", int'(oValid), int'(expV), 0);
    if (expV) checkSample(pipeQ[0]);
  end

  task automatic applyStimulus(input bit v, input int x, input int y, input bit strict);
    @(negedge clk);
    iValid    = v;
    iX        = IN_W'(x);
    iY        = IN_W'(y);
    strictNow = strict;
  endtask

  task automatic applyRandom(input bit v);
    applyStimulus(v, int'($urandom_range(0, 1023)) - 512,
                  int'($urandom_range(0, 1023)) - 512, 1'b0);
  endtask

  task automatic idleCycles(input int n);
    repeat (n) applyStimulus(1'b0, 0, 0, 1'b0);
  endtask

  task automatic stallCycles(input int n);
    @(negedge clk);
    en     = 1'b0;
    iValid = 1'b0;
    repeat (n) @(negedge clk);
    en = 1'b1;
  endtask

  initial begin
    rst       = 1'b1;
    en        = 1'b1;
    iValid    = 1'b0;
    iX        = '0;
    iY        = '0;
    strictNow = 1'b0;
    #12;
    checkOutput("rstValid", int'(oValid), 0, 0);
    checkOutput("rstAngle", int'(oAngle), 0, 0);
    checkOutput("rstAngleInt", int'(oAngleInt), 0, 0);
    checkOutput("rstMag", int'(oMag), 0, 0);
    checkOutput("rstZero", int'(oZero), 0, 0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] directed angles and axes");
    applyStimulus(1'b1, 2, 1, 1'b1);
    applyStimulus(1'b1, 0, -2, 1'b1);
    applyStimulus(1'b1, -1, 0, 1'b1);
    applyStimulus(1'b1, -1, -2, 1'b1);
    applyStimulus(1'b1, 0, 7, 1'b1);
    idleCycles(L + 2);

    $display("[TB] magnitude, extremes and zero input");
    applyStimulus(1'b1, 300, 400, 1'b1);
    applyStimulus(1'b1, -512, -512, 1'b1);
    applyStimulus(1'b1, 0, 0, 1'b1);
    applyStimulus(1'b1, 5, 0, 1'b1);
    applyStimulus(1'b1, -512, 511, 1'b1);
    idleCycles(L + 2);

    $display("[TB] random back-to-back then gapped");
    repeat (20) applyRandom(1'b1);
    repeat (20) applyRandom(1'($urandom_range(0, 1)));
    idleCycles(L + 2);

    $display("[TB] stall mid-fill and during drain");
    repeat (5) applyRandom(1'b1);
    stallCycles(7);
    repeat (5) applyRandom(1'b1);
    idleCycles(8);
    stallCycles(3);
    idleCycles(L + 2);

    $display("[TB] asynchronous reset with samples in flight");
    repeat (22) applyRandom(1'b1);
    @(negedge clk);
    iValid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checkOutput("asyncRstValid", int'(oValid), 0, 0);
    checkOutput("asyncRstMag", int'(oMag), 0, 0);
    checkOutput("asyncRstAngle", int'(oAngle), 0, 0);
    @(negedge clk);
    rst = 1'b0;
    idleCycles(L + 5);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
